// File: rtl/keypad_digit_buffer.sv
// Keypad entry buffer: registers and encodes a keypad, detects presses, and appends digits into NUM_DIGITS slots with backspace, clear and full policy.
// Latency: key_in -> key_q at edge N, press acted on at edge N+1 (N+DB_CYCLES with DEBOUNCE_EN); digits_out/key_valid are registered.
// Backpressure: none; every input is sampled each cycle. Optional macro DEBOUNCE_EN adds a stability filter of DB_CYCLES cycles.
module keypad_digit_buffer #(
   parameter int         KEYS       = 10,
   parameter int         NUM_DIGITS = 6,
   parameter int         OVERWRITE  = 0,
   parameter logic [3:0] BLANK      = 4'hF,
   parameter int         DB_CYCLES  = 4
) (
   input  logic                              clk,
   input  logic                              rst_ui,
   input  logic [KEYS-1:0]                   key_in,
   input  logic                              clr,
   input  logic                              bksp,
   output logic [NUM_DIGITS*4-1:0]           digits_out,
   output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_count,
   output logic                              full,
   output logic                              empty,
   output logic                              overflow,
   output logic                              key_valid,
   output logic [3:0]                        key_code
);

   localparam int            CW      = $clog2(NUM_DIGITS+1);
   localparam logic [CW-1:0] CNT_MAX = CW'(NUM_DIGITS);

   // Reject parameter sets the slot and code widths cannot represent.
   if (KEYS < 2 || KEYS > 16 || NUM_DIGITS < 1 || NUM_DIGITS > 16 || DB_CYCLES < 1) begin : g_bad_params
      $error("keypad_digit_buffer: parameter out of range");
   end

   typedef enum logic {IDLE = 1'b0, HELD = 1'b1} state_t;

   state_t          state, state_nxt;
   logic [KEYS-1:0] key_q;
   logic [3:0]      code;
   logic            press_ok, release_ok, press_evt;
   logic [3:0]      slots     [NUM_DIGITS];
   logic [3:0]      slots_nxt [NUM_DIGITS];
   logic [CW-1:0]   cnt_nxt;
   logic            ovf_nxt;
   logic            kv_nxt;
   logic [3:0]      kc_nxt;

   // Input register and FSM state; reset also forgets any key held across it.
   always_ff @(posedge clk) begin
      if (rst_ui) begin
         key_q <= '0;
         state <= IDLE;
      end else begin
         key_q <= key_in;
         state <= state_nxt;
      end
   end

   // Priority encoder: the lowest set key index wins.
   always_comb begin
      code = '0;
      for (int i = KEYS-1; i >= 0; i--) begin
         if (key_q[i]) code = 4'(i);
      end
   end

`ifdef DEBOUNCE_EN
   localparam int            DW     = $clog2(DB_CYCLES+1);
   localparam logic [DW-1:0] DB_MAX = DW'(DB_CYCLES);

   logic [KEYS-1:0] db_val;
   logic [DW-1:0]   db_cnt, db_run;

   // Length of the current run of identical key_q samples, saturating at DB_CYCLES.
   always_comb begin
      if (key_q == db_val) db_run = (db_cnt >= DB_MAX) ? DB_MAX : db_cnt + DW'(1);
      else                 db_run = DW'(1);
   end

   // Remember the previous sample and the run length it belongs to.
   always_ff @(posedge clk) begin
      if (rst_ui) begin
         db_val <= '0;
         db_cnt <= '0;
      end else begin
         db_val <= key_q;
         db_cnt <= db_run;
      end
   end

   assign press_ok   = (key_q != '0) && (db_run == DB_MAX);
   assign release_ok = (key_q == '0) && (db_run == DB_MAX);
`else
   assign press_ok   = (key_q != '0);
   assign release_ok = (key_q == '0);
`endif

   // Press detector: one event per press, nothing more until all keys are released.
   always_comb begin
      state_nxt = state;
      press_evt = 1'b0;
      case (state)
         IDLE: if (press_ok) begin
            press_evt = 1'b1;
            state_nxt = HELD;
         end
         HELD: if (release_ok) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Slot update with priority clr > bksp > press; a losing press is consumed silently.
   always_comb begin
      slots_nxt = slots;
      cnt_nxt   = digit_count;
      ovf_nxt   = overflow;
      kv_nxt    = 1'b0;
      kc_nxt    = key_code;
      if (clr) begin
         for (int k = 0; k < NUM_DIGITS; k++) slots_nxt[k] = BLANK;
         cnt_nxt = '0;
         ovf_nxt = 1'b0;
      end else if (bksp) begin
         if (digit_count != '0) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
               if (CW'(k) == digit_count - CW'(1)) slots_nxt[k] = BLANK;
            end
            cnt_nxt = digit_count - CW'(1);
         end
      end else if (press_evt) begin
         kv_nxt = 1'b1;
         kc_nxt = code;
         if (digit_count < CNT_MAX) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
               if (CW'(k) == digit_count) slots_nxt[k] = code;
            end
            cnt_nxt = digit_count + CW'(1);
         end else if (OVERWRITE != 0) begin
            for (int k = 0; k < NUM_DIGITS-1; k++) slots_nxt[k] = slots[k+1];
            slots_nxt[NUM_DIGITS-1] = code;
         end else begin
            ovf_nxt = 1'b1;
         end
      end
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (rst_ui) begin
         for (int k = 0; k < NUM_DIGITS; k++) slots[k] <= BLANK;
         digit_count <= '0;
         overflow    <= 1'b0;
         key_valid   <= 1'b0;
         key_code    <= '0;
      end else begin
         for (int k = 0; k < NUM_DIGITS; k++) slots[k] <= slots_nxt[k];
         digit_count <= cnt_nxt;
         overflow    <= ovf_nxt;
         key_valid   <= kv_nxt;
         key_code    <= kc_nxt;
      end
   end

   // Flatten slots onto the output bus, slot 0 in the low nibble.
   always_comb begin
      digits_out = '0;
      for (int k = 0; k < NUM_DIGITS; k++) digits_out[4*k +: 4] = slots[k];
   end

   assign full  = (digit_count == CNT_MAX);
   assign empty = (digit_count == '0);

endmodule

// File: tb/tb_keypad_digit_buffer.sv
// Bench for keypad_digit_buffer: two instances (drop and overwrite policy) share stimulus.
// Directed table, corner-case sequences and random traffic, all checked every cycle against a queue model.
// Debounce expectations follow DEBOUNCE_EN when it is defined for the build.
module tb_keypad_digit_buffer;

   localparam int KEYS = 10;
   localparam int ND   = 6;
   localparam int DB   = 4;
`ifdef DEBOUNCE_EN
   localparam int DB_EFF = DB;
`else
   localparam int DB_EFF = 1;
`endif

   logic            clk = 1'b0;
   logic            rst_ui, clr, bksp;
   logic [KEYS-1:0] key_in;
   logic [ND*4-1:0] d0, d1;
   logic [2:0]      c0, c1;
   logic            f0, f1, e0, e1, o0, o1, v0, v1;
   logic [3:0]      k0, k1;

   always #5 clk = ~clk;

   keypad_digit_buffer #(.KEYS(KEYS), .NUM_DIGITS(ND), .OVERWRITE(0), .BLANK(4'hF), .DB_CYCLES(DB)) u0 (
      .clk(clk), .rst_ui(rst_ui), .key_in(key_in), .clr(clr), .bksp(bksp),
      .digits_out(d0), .digit_count(c0), .full(f0), .empty(e0), .overflow(o0),
      .key_valid(v0), .key_code(k0));

   keypad_digit_buffer #(.KEYS(KEYS), .NUM_DIGITS(ND), .OVERWRITE(1), .BLANK(4'hF), .DB_CYCLES(DB)) u1 (
      .clk(clk), .rst_ui(rst_ui), .key_in(key_in), .clr(clr), .bksp(bksp),
      .digits_out(d1), .digit_count(c1), .full(f1), .empty(e1), .overflow(o1),
      .key_valid(v1), .key_code(k1));

   int tests = 0, fails = 0, pulses = 0, cyc = 0, last_pulse = 0;

   // Reference model: digit queues, sticky flags and a history of sampled key sets.
   logic [3:0]      q0[$], q1[$];
   logic [KEYS-1:0] m_kq = '0;
   logic [KEYS-1:0] m_hist[$];
   bit              m_held = 0, m_ovf0 = 0, m_ovf1 = 0, m_kv = 0;
   logic [3:0]      m_kc = '0;

   function automatic logic [ND*4-1:0] pack(input logic [3:0] q[$]);
      logic [ND*4-1:0] v;
      for (int k = 0; k < ND; k++) v[4*k +: 4] = (k < q.size()) ? q[k] : 4'hF;
      return v;
   endfunction

   function automatic logic [3:0] lowest(input logic [KEYS-1:0] m);
      for (int i = 0; i < KEYS; i++) if (m[i]) return 4'(i);
      return 4'd0;
   endfunction

   // Expected effect of the coming clock edge given the inputs now applied.
   task automatic model_edge();
      int run;
      bit ev;
      if (rst_ui) begin
         q0.delete(); q1.delete(); m_hist.delete();
         m_kq = '0; m_held = 0; m_ovf0 = 0; m_ovf1 = 0; m_kv = 0; m_kc = '0;
         return;
      end
      m_hist.push_back(m_kq);
      if (m_hist.size() > 32) void'(m_hist.pop_front());
      run = 0;
      for (int i = m_hist.size()-1; i >= 0; i--) begin
         if (m_hist[i] == m_kq) run++;
         else break;
      end
      ev = !m_held && (m_kq != '0) && (run >= DB_EFF);
      if (ev) m_held = 1;
      else if (m_held && (m_kq == '0) && (run >= DB_EFF)) m_held = 0;
      m_kv = 0;
      if (clr) begin
         q0.delete(); q1.delete(); m_ovf0 = 0; m_ovf1 = 0;
      end else if (bksp) begin
         if (q0.size() > 0) void'(q0.pop_back());
         if (q1.size() > 0) void'(q1.pop_back());
      end else if (ev) begin
         m_kv = 1;
         m_kc = lowest(m_kq);
         if (q0.size() < ND) q0.push_back(m_kc);
         else m_ovf0 = 1;
         if (q1.size() >= ND) void'(q1.pop_front());
         q1.push_back(m_kc);
      end
      m_kq = key_in;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic check_all();
      chk("u0.digits",   32'(d0), 32'(pack(q0)));
      chk("u1.digits",   32'(d1), 32'(pack(q1)));
      chk("u0.count",    32'(c0), 32'(q0.size()));
      chk("u1.count",    32'(c1), 32'(q1.size()));
      chk("u0.full",     32'(f0), 32'(q0.size() == ND));
      chk("u1.full",     32'(f1), 32'(q1.size() == ND));
      chk("u0.empty",    32'(e0), 32'(q0.size() == 0));
      chk("u1.empty",    32'(e1), 32'(q1.size() == 0));
      chk("u0.overflow", 32'(o0), 32'(m_ovf0));
      chk("u1.overflow", 32'(o1), 32'(m_ovf1));
      chk("u0.key_valid",32'(v0), 32'(m_kv));
      chk("u1.key_valid",32'(v1), 32'(m_kv));
      chk("u0.key_code", 32'(k0), 32'(m_kc));
      chk("u1.key_code", 32'(k1), 32'(m_kc));
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      cyc++;
      check_all();
      if (v0) begin
         pulses++;
         last_pulse = cyc;
      end
   endtask

   task automatic press(input int k);
      key_in = '0;
      key_in[k] = 1'b1;
      repeat (DB_EFF+2) step();
      key_in = '0;
      repeat (DB_EFF+2) step();
   endtask

   task automatic do_act(input int act, input int k);
      case (act)
         0: press(k);
         1: begin bksp = 1'b1; step(); bksp = 1'b0; step(); end
         default: begin clr = 1'b1; step(); clr = 1'b0; step(); end
      endcase
   endtask

   typedef struct {
      int          act;     // 0 press, 1 backspace, 2 clear
      int          key;
      int          cnt;
      int          kc;
      logic [23:0] dig0;    // drop-policy instance, slot5..slot0
      logic [23:0] dig1;    // overwrite-policy instance
      bit          ovf0;
      int          npulse;
   } vec_t;

   vec_t tbl[13];

   initial begin
      int p0, c_start;
      tbl[0]  = '{0, 2, 1, 2, 24'hFFFFF2, 24'hFFFFF2, 1'b0, 1};
      tbl[1]  = '{0, 1, 2, 1, 24'hFFFF12, 24'hFFFF12, 1'b0, 1};
      tbl[2]  = '{0, 9, 3, 9, 24'hFFF912, 24'hFFF912, 1'b0, 1};
      tbl[3]  = '{0, 3, 4, 3, 24'hFF3912, 24'hFF3912, 1'b0, 1};
      tbl[4]  = '{0, 5, 5, 5, 24'hF53912, 24'hF53912, 1'b0, 1};
      tbl[5]  = '{0, 4, 6, 4, 24'h453912, 24'h453912, 1'b0, 1};
      tbl[6]  = '{0, 7, 6, 7, 24'h453912, 24'h745391, 1'b1, 1};
      tbl[7]  = '{2, 0, 0, 7, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 0};
      tbl[8]  = '{0, 8, 1, 8, 24'hFFFFF8, 24'hFFFFF8, 1'b0, 1};
      tbl[9]  = '{0, 6, 2, 6, 24'hFFFF68, 24'hFFFF68, 1'b0, 1};
      tbl[10] = '{1, 0, 1, 6, 24'hFFFFF8, 24'hFFFFF8, 1'b0, 0};
      tbl[11] = '{1, 0, 0, 6, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 0};
      tbl[12] = '{1, 0, 0, 6, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 0};

      rst_ui = 1'b1; clr = 1'b0; bksp = 1'b0; key_in = '0;
      step(); step();
      chk("reset.digits", 32'(d0), 32'h00FFFFFF);
      chk("reset.count",  32'(c0), 32'd0);
      chk("reset.empty",  32'(e0), 32'd1);
      chk("reset.full",   32'(f0), 32'd0);
      rst_ui = 1'b0;
      step();

      // Entry, full policy, clear and backspace.
      for (int i = 0; i < 13; i++) begin
         p0 = pulses;
         do_act(tbl[i].act, tbl[i].key);
         chk($sformatf("row%0d.dig0", i),   32'(d0), 32'(tbl[i].dig0));
         chk($sformatf("row%0d.dig1", i),   32'(d1), 32'(tbl[i].dig1));
         chk($sformatf("row%0d.count", i),  32'(c0), 32'(tbl[i].cnt));
         chk($sformatf("row%0d.code", i),   32'(k0), 32'(tbl[i].kc));
         chk($sformatf("row%0d.ovf0", i),   32'(o0), 32'(tbl[i].ovf0));
         chk($sformatf("row%0d.ovf1", i),   32'(o1), 32'd0);
         chk($sformatf("row%0d.pulses", i), 32'(pulses - p0), 32'(tbl[i].npulse));
      end

      // Multi-hot: lowest key wins, key-set changes while held give no new event.
      p0 = pulses;
      key_in = '0; key_in[3] = 1'b1; key_in[7] = 1'b1;
      repeat (DB_EFF+2) step();
      key_in[7] = 1'b0; key_in[5] = 1'b1;
      repeat (DB_EFF+2) step();
      key_in = '0;
      repeat (DB_EFF+2) step();
      chk("multihot.pulses", 32'(pulses - p0), 32'd1);
      chk("multihot.code",   32'(k0), 32'd3);
      chk("multihot.digits", 32'(d0), 32'h00FFFFF3);

      // Clear in the same cycle the press event fires: press is consumed.
      p0 = pulses;
      key_in = '0; key_in[4] = 1'b1;
      repeat (DB_EFF) step();
      clr = 1'b1; step(); clr = 1'b0;
      repeat (2) step();
      key_in = '0;
      repeat (DB_EFF+2) step();
      chk("clrpress.pulses", 32'(pulses - p0), 32'd0);
      chk("clrpress.count",  32'(c0), 32'd0);
      chk("clrpress.digits", 32'(d0), 32'h00FFFFFF);
      chk("clrpress.code",   32'(k0), 32'd3);

      // Reset while a key is held mid-entry, then a fresh press after release.
      key_in = '0; key_in[1] = 1'b1;
      repeat (DB_EFF+2) step();
      chk("midrst.pre_count", 32'(c0), 32'd1);
      rst_ui = 1'b1;
      step(); step();
      chk("midrst.count",  32'(c0), 32'd0);
      chk("midrst.empty",  32'(e0), 32'd1);
      chk("midrst.code",   32'(k0), 32'd0);
      chk("midrst.digits", 32'(d0), 32'h00FFFFFF);
      key_in = '0;
      step();
      rst_ui = 1'b0;
      repeat (DB_EFF+2) step();
      p0 = pulses;
      press(2);
      chk("postrst.pulses", 32'(pulses - p0), 32'd1);
      chk("postrst.code",   32'(k0), 32'd2);
      chk("postrst.count",  32'(c0), 32'd1);

`ifdef DEBOUNCE_EN
      // A press shorter than the stability window is ignored.
      p0 = pulses;
      key_in = '0; key_in[6] = 1'b1;
      repeat (DB_EFF-1) step();
      key_in = '0;
      repeat (DB_EFF+2) step();
      chk("short.pulses", 32'(pulses - p0), 32'd0);
`endif

      // Press latency measured in edges from key assertion.
      p0 = pulses;
      c_start = cyc;
      press(6);
      chk("latency.pulses", 32'(pulses - p0), 32'd1);
      chk("latency.edges",  32'(last_pulse - c_start), 32'(DB_EFF + 1));

      // Random traffic against the model.
      for (int n = 0; n < 800; n++) begin
         rst_ui = ($urandom_range(0, 99) == 0);
         clr    = ($urandom_range(0, 39) == 0);
         bksp   = ($urandom_range(0, 11) == 0);
         if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 3))
               0, 1: key_in = '0;
               2: begin key_in = '0; key_in[$urandom_range(0, KEYS-1)] = 1'b1; end
               default: key_in = KEYS'($urandom);
            endcase
         end
         step();
      end
      rst_ui = 1'b0; clr = 1'b0; bksp = 1'b0; key_in = '0;
      repeat (DB_EFF+2) step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
